// File: rtl/led_shift_flash_pkg.sv
// rtl/led_shift_flash_pkg.sv - shared bit indices, state types and prescaler limits
package led_shift_flash_pkg;

  localparam int BTN_MODE  = 0;
  localparam int BTN_BLUE  = 1;
  localparam int BTN_RED   = 2;
  localparam int BTN_GREEN = 3;

  localparam int SW_EN       = 0;
  localparam int SW_SPEED_LO = 1;
  localparam int SW_SPEED_HI = 2;
  localparam int SW_DIR      = 3;

  typedef enum logic {
    MODE_FLASH = 1'b0,
    MODE_SHIFT = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    COLOUR_BLUE  = 2'd0,
    COLOUR_RED   = 2'd1,
    COLOUR_GREEN = 2'd2
  } colour_e;

  // Each speed step halves the tick period.
  function automatic int limit_speed0(input int nb);
    return (1 << (nb - 1)) - 1;
  endfunction

  function automatic int limit_speed1(input int nb);
    return (1 << (nb - 2)) - 1;
  endfunction

  function automatic int limit_speed2(input int nb);
    return (1 << (nb - 3)) - 1;
  endfunction

  function automatic int limit_speed3(input int nb);
    return (1 << (nb - 4)) - 1;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - enable-gated prescaler producing a one-cycle tick
module led_tick_gen
  import led_shift_flash_pkg::*;
#(
  parameter int NB_COUNTER = 16
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [1:0] i_speed,
  output logic       o_tick
);

  localparam logic [NB_COUNTER-1:0] LIMIT_0 = NB_COUNTER'(limit_speed0(NB_COUNTER));
  localparam logic [NB_COUNTER-1:0] LIMIT_1 = NB_COUNTER'(limit_speed1(NB_COUNTER));
  localparam logic [NB_COUNTER-1:0] LIMIT_2 = NB_COUNTER'(limit_speed2(NB_COUNTER));
  localparam logic [NB_COUNTER-1:0] LIMIT_3 = NB_COUNTER'(limit_speed3(NB_COUNTER));

  logic [NB_COUNTER-1:0] counter;
  logic [NB_COUNTER-1:0] limit;

  always_comb begin
    limit = LIMIT_0;
    case (i_speed)
      2'b01:   limit = LIMIT_1;
      2'b10:   limit = LIMIT_2;
      2'b11:   limit = LIMIT_3;
      default: limit = LIMIT_0;
    endcase
  end

  // >= rather than == so a speed-up past the current count wraps at once.
  assign o_tick = i_enable && (counter >= limit);

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      counter <= '0;
    end else if (!i_enable || o_tick) begin
      counter <= '0;
    end else begin
      counter <= counter + NB_COUNTER'(1);
    end
  end

endmodule

// File: rtl/led_shift_flash_top.sv
// rtl/led_shift_flash_top.sv - button-controlled flash/shift LED pattern generator
module led_shift_flash_top
  import led_shift_flash_pkg::*;
#(
  parameter int NB_SW      = 4,
  parameter int NB_BTN     = 4,
  parameter int NB_COUNTER = 16,
  parameter int NB_LEDS    = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic [NB_BTN-1:0]  i_btn,
  output logic [NB_LEDS-1:0] o_led,
  output logic [NB_LEDS-1:0] o_led_b,
  output logic [NB_LEDS-1:0] o_led_r,
  output logic [NB_LEDS-1:0] o_led_g
);

  logic [NB_BTN-1:0]  btn_d;
  logic [NB_BTN-1:0]  btn_rise;
  mode_e              mode_q;
  mode_e              mode_d;
  colour_e            colour_q;
  colour_e            colour_d;
  logic [NB_LEDS-1:0] flash_q;
  logic [NB_LEDS-1:0] shift_q;
  logic [NB_LEDS-1:0] pattern;
  logic               tick;

  led_tick_gen #(
    .NB_COUNTER (NB_COUNTER)
  ) u_tick_gen (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_sw[SW_EN]),
    .i_speed  (i_sw[SW_SPEED_HI:SW_SPEED_LO]),
    .o_tick   (tick)
  );

  assign btn_rise = i_btn & ~btn_d;

  always_comb begin
    mode_d   = mode_q;
    colour_d = colour_q;
    if (btn_rise[BTN_MODE]) begin
      mode_d = (mode_q == MODE_FLASH) ? MODE_SHIFT : MODE_FLASH;
    end
    if (btn_rise[BTN_BLUE]) begin
      colour_d = COLOUR_BLUE;
    end else if (btn_rise[BTN_RED]) begin
      colour_d = COLOUR_RED;
    end else if (btn_rise[BTN_GREEN]) begin
      colour_d = COLOUR_GREEN;
    end
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      btn_d    <= '0;
      mode_q   <= MODE_FLASH;
      colour_q <= COLOUR_RED;
    end else begin
      btn_d    <= i_btn;
      mode_q   <= mode_d;
      colour_q <= colour_d;
    end
  end

  // Both patterns run continuously so a mode switch shows the live phase.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      flash_q <= '0;
      shift_q <= NB_LEDS'(1);
    end else if (tick) begin
      flash_q <= ~flash_q;
      if (i_sw[SW_DIR]) begin
        shift_q <= {shift_q[0], shift_q[NB_LEDS-1:1]};
      end else begin
        shift_q <= {shift_q[NB_LEDS-2:0], shift_q[NB_LEDS-1]};
      end
    end
  end

  always_comb begin
    pattern = (mode_q == MODE_SHIFT) ? shift_q : flash_q;
    o_led_b = (colour_q == COLOUR_BLUE)  ? pattern : '0;
    o_led_r = (colour_q == COLOUR_RED)   ? pattern : '0;
    o_led_g = (colour_q == COLOUR_GREEN) ? pattern : '0;
    o_led   = NB_LEDS'({colour_q == COLOUR_GREEN, colour_q == COLOUR_RED,
                        colour_q == COLOUR_BLUE, mode_q == MODE_SHIFT});
  end

endmodule

// File: tb/tb_led_shift_flash_top.sv
// tb/tb_led_shift_flash_top.sv - scoreboard and vector-table bench for led_shift_flash_top
module tb_led_shift_flash_top;

  localparam int NB_COUNTER = 12;

  logic       clock = 1'b0;
  logic       i_reset = 1'b0;
  logic [3:0] i_sw = 4'b0000;
  logic [3:0] i_btn = 4'b0000;
  logic [3:0] o_led;
  logic [3:0] o_led_b;
  logic [3:0] o_led_r;
  logic [3:0] o_led_g;

  always #5 clock = ~clock;

  led_shift_flash_top #(
    .NB_SW      (4),
    .NB_BTN     (4),
    .NB_COUNTER (NB_COUNTER),
    .NB_LEDS    (4)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_sw    (i_sw),
    .i_btn   (i_btn),
    .o_led   (o_led),
    .o_led_b (o_led_b),
    .o_led_r (o_led_r),
    .o_led_g (o_led_g)
  );

  typedef struct packed {
    int         cyc;
    logic [3:0] led;
    logic [3:0] b;
    logic [3:0] r;
    logic [3:0] g;
  } ev_t;

  typedef struct packed {
    logic [3:0] btn;
    int         hold;
    logic [3:0] led;
    logic [3:0] b;
    logic [3:0] r;
    logic [3:0] g;
  } row_t;

  ev_t   sb[$];
  string sb_name[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  logic [15:0] prev_out;

  bit         m_mode;
  int         m_col;
  logic [3:0] m_flash;
  logic [3:0] m_shift;
  logic [3:0] m_sw;
  int         t_last;
  int         sw_chg;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  function automatic int period(input logic [1:0] s);
    return 1 << (NB_COUNTER - 1 - int'(s));
  endfunction

  function automatic ev_t model_ev(input int c);
    ev_t e;
    logic [3:0] pat;
    pat   = m_mode ? m_shift : m_flash;
    e.cyc = c;
    e.led = {m_col == 2, m_col == 1, m_col == 0, m_mode};
    e.b   = (m_col == 0) ? pat : 4'b0000;
    e.r   = (m_col == 1) ? pat : 4'b0000;
    e.g   = (m_col == 2) ? pat : 4'b0000;
    return e;
  endfunction

  always @(negedge clock) begin
    logic [15:0] cur;
    ev_t e;
    string nm;
    cur = {o_led, o_led_b, o_led_r, o_led_g};
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e  = sb.pop_front();
        nm = sb_name.pop_front();
        chk({nm, "_led"}, o_led, e.led);
        chk({nm, "_b"}, o_led_b, e.b);
        chk({nm, "_r"}, o_led_r, e.r);
        chk({nm, "_g"}, o_led_g, e.g);
      end else if (cur !== prev_out) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change at cycle %0d: got %h expected %h", cyc, cur, prev_out);
      end
    end
    prev_out = cur;
  end

  task automatic push(input ev_t e, input string nm);
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clock);
    @(negedge clock);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout at cycle %0d: got %0d pending expected 0", nm, cyc, sb.size());
      sb.delete();
      sb_name.delete();
    end
  endtask

  task automatic press_raw(input logic [3:0] btn, input int hold, input ev_t e, input string nm);
    e.cyc = cyc + 1;
    push(e, nm);
    i_btn = btn;
    repeat (hold) @(negedge clock);
    i_btn = 4'b0000;
    @(negedge clock);
    wait_drain(4, nm);
  endtask

  task automatic press(input logic [3:0] btn, input int hold, input string nm);
    m_mode = m_mode ^ btn[0];
    if (btn[1]) m_col = 0;
    else if (btn[2]) m_col = 1;
    else if (btn[3]) m_col = 2;
    press_raw(btn, hold, model_ev(cyc + 1), nm);
  endtask

  task automatic set_sw(input logic [3:0] v);
    if (!m_sw[0] && v[0]) t_last = cyc;
    sw_chg = cyc;
    m_sw   = v;
    i_sw   = v;
  endtask

  task automatic run_ticks(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      int lim;
      int e;
      lim = period(m_sw[2:1]) - 1;
      e   = t_last + lim + 1;
      if (sw_chg + 1 > e) e = sw_chg + 1;
      m_flash = ~m_flash;
      m_shift = m_sw[3] ? {m_shift[0], m_shift[3:1]} : {m_shift[2:0], m_shift[3]};
      t_last  = e;
      push(model_ev(e), $sformatf("%s%0d", nm, i));
      wait_drain(lim + 16, nm);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[8];
    rows[0] = '{btn: 4'b0010, hold: 1,   led: 4'b0010, b: 4'b0000, r: 4'b0000, g: 4'b0000};
    rows[1] = '{btn: 4'b1000, hold: 2,   led: 4'b1000, b: 4'b0000, r: 4'b0000, g: 4'b0000};
    rows[2] = '{btn: 4'b0110, hold: 1,   led: 4'b0010, b: 4'b0000, r: 4'b0000, g: 4'b0000};
    rows[3] = '{btn: 4'b0011, hold: 1,   led: 4'b0011, b: 4'b0001, r: 4'b0000, g: 4'b0000};
    rows[4] = '{btn: 4'b0001, hold: 500, led: 4'b0010, b: 4'b0000, r: 4'b0000, g: 4'b0000};
    rows[5] = '{btn: 4'b1100, hold: 3,   led: 4'b0100, b: 4'b0000, r: 4'b0000, g: 4'b0000};
    rows[6] = '{btn: 4'b1001, hold: 1,   led: 4'b1001, b: 4'b0000, r: 4'b0000, g: 4'b0001};
    rows[7] = '{btn: 4'b0001, hold: 1,   led: 4'b1000, b: 4'b0000, r: 4'b0000, g: 4'b0000};

    i_reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("reset_led", o_led, 4'b0100);
    chk("reset_b", o_led_b, 4'b0000);
    chk("reset_r", o_led_r, 4'b0000);
    chk("reset_g", o_led_g, 4'b0000);
    i_reset = 1'b1;
    m_mode = 1'b0; m_col = 1; m_flash = 4'b0000; m_shift = 4'b0001;
    m_sw = 4'b0000; t_last = cyc; sw_chg = cyc;
    mon_en = 1'b1;

    repeat (10000) @(negedge clock);
    chk("idle_led", o_led, 4'b0100);
    chk("idle_r", o_led_r, 4'b0000);

    for (int i = 0; i < 8; i++) begin
      ev_t e;
      e.cyc = 0;
      e.led = rows[i].led; e.b = rows[i].b; e.r = rows[i].r; e.g = rows[i].g;
      press_raw(rows[i].btn, rows[i].hold, e, $sformatf("btn_row%0d", i));
    end
    m_mode = 1'b0;
    m_col  = 2;

    press(4'b0010, 5, "sel_blue");
    set_sw(4'b0101);
    run_ticks(3, "flash_blue");

    repeat (100) @(negedge clock);
    set_sw(4'b0011);
    run_ticks(2, "speed01");
    repeat (700) @(negedge clock);
    set_sw(4'b0111);
    run_ticks(3, "speed11_drop");

    press(4'b0001, 1, "to_shift");
    press(4'b1000, 1, "sel_green");
    chk("shift_green_led", o_led, 4'b1001);
    run_ticks(4, "shift_fwd");
    set_sw(4'b1111);
    run_ticks(4, "shift_rev");

    // A mode press landing on the reset edge must not survive the reset.
    i_reset = 1'b0;
    i_btn   = 4'b0001;
    m_mode = 1'b0; m_col = 1; m_flash = 4'b0000; m_shift = 4'b0001;
    push(model_ev(cyc + 1), "mid_reset");
    @(negedge clock);
    i_btn = 4'b0000;
    repeat (499) @(negedge clock);
    chk("mid_reset_led", o_led, 4'b0100);
    chk("mid_reset_g", o_led_g, 4'b0000);
    i_reset = 1'b1;
    i_sw    = 4'b1111;
    m_sw    = 4'b1111;
    t_last  = cyc;
    sw_chg  = cyc;
    run_ticks(2, "post_reset_flash");

    wait_drain(4, "final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
